// File: rtl/mutex_rule_scheduler_if.sv
// Signal bundle between the stimulus/control side and the rule scheduler.
// The master drives run/step/guard_ok; the slave (scheduler) drives the enables and status.
interface mutex_rule_scheduler_if #(
    parameter int NUM_RULES = 4,
    parameter int IDX_W     = 2,
    parameter int CNT_W     = 16
);
    logic                 run;
    logic                 step;
    logic [NUM_RULES-1:0] guard_ok;
    logic [NUM_RULES-1:0] io_en_a;
    logic                 fired;
    logic [IDX_W-1:0]     fired_idx;
    logic [CNT_W-1:0]     fire_count;
    logic                 deadlock;
    logic                 starve;
    logic [IDX_W-1:0]     starve_idx;
    logic                 busy;

    modport master (
        output run, step, guard_ok,
        input  io_en_a, fired, fired_idx, fire_count, deadlock, starve, starve_idx, busy
    );

    modport slave (
        input  run, step, guard_ok,
        output io_en_a, fired, fired_idx, fire_count, deadlock, starve, starve_idx, busy
    );
endinterface

// File: rtl/mutex_rule_scheduler.sv
// Round-robin scheduler firing at most one guarded rule per two-cycle slot, with
// single-step, sticky deadlock detection and a per-rule starvation checker.
module mutex_rule_scheduler #(
    parameter int NUM_RULES      = 4,
    parameter int IDX_W          = 2,
    parameter int STARVE_LIMIT   = 15,
    parameter int DEADLOCK_LIMIT = 8,
    parameter int CNT_W          = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    mutex_rule_scheduler_if.slave  bus
);
    localparam int DL_W = $clog2(DEADLOCK_LIMIT + 1);
    localparam int ST_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, EVAL, FIRE, HALT} state_t;

    state_t               state_q, state_d;
    logic                 cont_q, cont_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [NUM_RULES-1:0] en_q, en_d;
    logic                 fired_q, fired_d;
    logic [IDX_W-1:0]     fired_idx_q, fired_idx_d;
    logic [CNT_W-1:0]     fire_count_q, fire_count_d;
    logic [DL_W-1:0]      dl_cnt_q, dl_cnt_d;
    logic                 deadlock_q, deadlock_d;
    logic                 starve_q, starve_d;
    logic [IDX_W-1:0]     starve_idx_q, starve_idx_d;
    logic [ST_W-1:0]      starve_cnt_q [NUM_RULES];
    logic [ST_W-1:0]      starve_cnt_d [NUM_RULES];

    logic                 grant_vld;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     cand;
    logic                 hit;
    logic [IDX_W-1:0]     hit_idx;

    // Scan from the farthest offset down so the candidate nearest ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_RULES - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_RULES);
            if (bus.guard_ok[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cont_d       = cont_q;
        ptr_d        = ptr_q;
        en_d         = '0;
        fired_d      = 1'b0;
        fired_idx_d  = fired_idx_q;
        fire_count_d = fire_count_q;
        dl_cnt_d     = dl_cnt_q;
        deadlock_d   = deadlock_q;
        starve_d     = starve_q;
        starve_idx_d = starve_idx_q;
        starve_cnt_d = starve_cnt_q;
        hit          = 1'b0;
        hit_idx      = '0;

        case (state_q)
            IDLE: begin
                if (bus.run) begin
                    state_d = EVAL;
                    cont_d  = 1'b1;
                end else if (bus.step) begin
                    state_d = EVAL;
                    cont_d  = 1'b0;
                end
            end

            EVAL: begin
                for (int i = 0; i < NUM_RULES; i++) begin
                    if (bus.guard_ok[i] && !(grant_vld && grant_idx == IDX_W'(i))) begin
                        starve_cnt_d[i] = (starve_cnt_q[i] == ST_W'(STARVE_LIMIT)) ?
                                          starve_cnt_q[i] : starve_cnt_q[i] + 1'b1;
                    end else begin
                        starve_cnt_d[i] = '0;
                    end
                end
                for (int i = NUM_RULES - 1; i >= 0; i--) begin
                    if (starve_cnt_d[i] == ST_W'(STARVE_LIMIT)) begin
                        hit     = 1'b1;
                        hit_idx = IDX_W'(i);
                    end
                end
                // Only the first starvation event is recorded.
                if (hit && !starve_q) begin
                    starve_d     = 1'b1;
                    starve_idx_d = hit_idx;
                end

                if (grant_vld) begin
                    en_d         = NUM_RULES'(1) << grant_idx;
                    fired_d      = 1'b1;
                    fired_idx_d  = grant_idx;
                    fire_count_d = (fire_count_q == '1) ? fire_count_q : fire_count_q + 1'b1;
                    ptr_d        = IDX_W'((int'(grant_idx) + 1) % NUM_RULES);
                    dl_cnt_d     = '0;
                    state_d      = FIRE;
                end else begin
                    dl_cnt_d = dl_cnt_q + 1'b1;
                    if (dl_cnt_d == DL_W'(DEADLOCK_LIMIT)) begin
                        deadlock_d = 1'b1;
                        state_d    = HALT;
                    end else begin
                        state_d = cont_q ? EVAL : IDLE;
                    end
                end
            end

            FIRE: begin
                state_d = (cont_q && bus.run) ? EVAL : IDLE;
            end

            default: begin
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cont_q       <= 1'b0;
            ptr_q        <= '0;
            en_q         <= '0;
            fired_q      <= 1'b0;
            fired_idx_q  <= '0;
            fire_count_q <= '0;
            dl_cnt_q     <= '0;
            deadlock_q   <= 1'b0;
            starve_q     <= 1'b0;
            starve_idx_q <= '0;
            for (int i = 0; i < NUM_RULES; i++) starve_cnt_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            cont_q       <= cont_d;
            ptr_q        <= ptr_d;
            en_q         <= en_d;
            fired_q      <= fired_d;
            fired_idx_q  <= fired_idx_d;
            fire_count_q <= fire_count_d;
            dl_cnt_q     <= dl_cnt_d;
            deadlock_q   <= deadlock_d;
            starve_q     <= starve_d;
            starve_idx_q <= starve_idx_d;
            for (int i = 0; i < NUM_RULES; i++) starve_cnt_q[i] <= starve_cnt_d[i];
        end
    end

    assign bus.io_en_a    = en_q;
    assign bus.fired      = fired_q;
    assign bus.fired_idx  = fired_idx_q;
    assign bus.fire_count = fire_count_q;
    assign bus.deadlock   = deadlock_q;
    assign bus.starve     = starve_q;
    assign bus.starve_idx = starve_idx_q;
    assign bus.busy       = (state_q == EVAL) || (state_q == FIRE);
endmodule

// File: tb/tb_mutex_rule_scheduler.sv
// Scoreboard bench for mutex_rule_scheduler: a round-robin reference model queues the
// expected grants and a negedge monitor compares every fire against them.
module tb_mutex_rule_scheduler;
    localparam int NR = 4;

    typedef struct {
        int idx;
        int count;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mutex_rule_scheduler_if #(.NUM_RULES(NR), .IDX_W(2), .CNT_W(16)) bus ();

    mutex_rule_scheduler #(
        .NUM_RULES(NR), .IDX_W(2), .STARVE_LIMIT(15), .DEADLOCK_LIMIT(8), .CNT_W(16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    bit   sb_en   = 1'b1;
    bit   prev_fired = 1'b0;
    int   m_ptr = 0, m_count = 0, m_dl = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: first true guard at or after ptr, wrapping.
    function automatic int rr_grant(input int ptr, input logic [NR-1:0] g);
        for (int k = 0; k < NR; k++) begin
            if (g[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic void model_fire(input logic [NR-1:0] g);
        exp_t e;
        e.idx   = rr_grant(m_ptr, g);
        m_ptr   = (e.idx + 1) % NR;
        m_count = (m_count == 65535) ? m_count : m_count + 1;
        e.count = m_count;
        m_dl    = 0;
        sb_q.push_back(e);
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (reset === 1'b0) begin
            chk("en_onehot0", $onehot0(bus.io_en_a), 1);
            chk("fired_vs_en", bus.fired, bus.io_en_a != 0);
            if (bus.fired) begin
                chk("no_back_to_back", prev_fired, 0);
                if (sb_en) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_fire", bus.io_en_a, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("io_en_a", bus.io_en_a, 1 << e.idx);
                        chk("fired_idx", bus.fired_idx, e.idx);
                        chk("fire_count", bus.fire_count, e.count);
                    end
                end
            end
            prev_fired = bus.fired;
        end else begin
            prev_fired = 1'b0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_io_en_a"}, bus.io_en_a, 0);
        chk({tag, "_fired"}, bus.fired, 0);
        chk({tag, "_fired_idx"}, bus.fired_idx, 0);
        chk({tag, "_fire_count"}, bus.fire_count, 0);
        chk({tag, "_deadlock"}, bus.deadlock, 0);
        chk({tag, "_starve"}, bus.starve, 0);
        chk({tag, "_starve_idx"}, bus.starve_idx, 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.run = 1'b0;
        bus.step = 1'b0;
        bus.guard_ok = '0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("rst");
        @(negedge clock);
        reset = 1'b0;
        sb_q.delete();
        m_ptr = 0; m_count = 0; m_dl = 0;
        @(posedge clock);
        #1;
    endtask

    // Run continuously on a constant guard until m fires, dropping run in the last FIRE.
    task automatic burst(input logic [NR-1:0] g, input int m);
        int n = 0, cyc = 0;
        for (int i = 0; i < m; i++) model_fire(g);
        bus.guard_ok = g;
        bus.run = 1'b1;
        while (n < m && cyc < 4 * m + 20) begin
            @(posedge clock);
            #1;
            cyc++;
            if (bus.fired) n++;
        end
        bus.run = 1'b0;
        chk("burst_fires", n, m);
        repeat (3) @(posedge clock);
        #1;
        chk("sb_drained", sb_q.size(), 0);
        chk("burst_idle", bus.busy, 0);
        sb_q.delete();
    endtask

    task automatic single_step(input logic [NR-1:0] g);
        if (g != 0) model_fire(g);
        else m_dl++;
        bus.guard_ok = g;
        bus.step = 1'b1;
        @(posedge clock);
        #1;
        bus.step = 1'b0;
        @(posedge clock);
        #1;
        bus.guard_ok = NR'($urandom);
        repeat (2) @(posedge clock);
        #1;
        chk("step_idle", bus.busy, 0);
        chk("step_drained", sb_q.size(), 0);
        if (m_dl == 8) begin
            chk("step_deadlock", bus.deadlock, 1);
            do_reset();
        end else begin
            chk("step_deadlock", bus.deadlock, 0);
        end
    endtask

    initial begin
        bus.run = 1'b0;
        bus.step = 1'b0;
        bus.guard_ok = '0;

        // Asynchronous reset in the middle of a FIRE cycle.
        do_reset();
        model_fire(4'b1111);
        bus.guard_ok = 4'b1111;
        bus.run = 1'b1;
        for (int c = 0; c < 10 && !bus.fired; c++) begin
            @(posedge clock);
            #1;
        end
        chk("midfire_en", bus.io_en_a, 4'b0001);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async");
        do_reset();

        // Rotation from ptr=0 on all-true guards, then pointer skip.
        burst(4'b1111, 9);
        do_reset();
        burst(4'b1010, 3);

        // Single-step on 0011: two fires, idle in between.
        do_reset();
        single_step(4'b0011);
        single_step(4'b0011);
        repeat (6) @(posedge clock);
        #1;
        chk("step_no_more", bus.io_en_a, 0);

        // Deadlock after the 8th empty evaluation, then HALT ignores run/step.
        do_reset();
        bus.guard_ok = '0;
        bus.run = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        chk("dl_before", bus.deadlock, 0);
        @(posedge clock);
        #1;
        chk("dl_set", bus.deadlock, 1);
        chk("dl_halt_busy", bus.busy, 0);
        bus.guard_ok = 4'b1111;
        bus.step = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        bus.step = 1'b0;
        bus.run = 1'b0;
        chk("halt_en", bus.io_en_a, 0);
        chk("halt_count", bus.fire_count, 0);
        chk("halt_dl", bus.deadlock, 1);

        // Starvation of rule 2 with the pointer pinned at 0.
        do_reset();
        sb_en = 1'b0;
        force dut.ptr_q = 2'b00;
        bus.guard_ok = 4'b0101;
        bus.run = 1'b1;
        repeat (29) @(posedge clock);
        #1;
        chk("starve_before", bus.starve, 0);
        @(posedge clock);
        #1;
        chk("starve_set", bus.starve, 1);
        chk("starve_idx", bus.starve_idx, 2);
        chk("starve_running", bus.busy, 1);
        bus.run = 1'b0;
        repeat (4) @(posedge clock);
        release dut.ptr_q;
        sb_en = 1'b1;

        // Long fair run must never flag starvation.
        do_reset();
        burst(4'b1111, 100);
        chk("fair_no_starve", bus.starve, 0);

        // Randomized bursts and single steps against the model.
        do_reset();
        for (int it = 0; it < 8; it++) begin
            burst(NR'($urandom_range(1, 15)), $urandom_range(1, 6));
        end
        for (int it = 0; it < 40; it++) begin
            single_step(($urandom_range(0, 3) == 0) ? 4'b0000 : NR'($urandom_range(1, 15)));
        end
        for (int it = 0; it < 8; it++) single_step(4'b0000);
        chk("rand_no_starve", bus.starve, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mutex_rule_scheduler.md
Name: mutex_rule_scheduler

Overview:
Round-robin rule scheduler for the generated mutual-exclusion `system` module. It samples the per-rule guard vector and drives the one-hot rule-enable bus (`io_en_a`) so that at most one guarded rule fires per firing slot. It sits between the free-running stimulus/control logic and `system`. It also provides single-step, deadlock detection and starvation checking for equivalence and trace runs.

Parameters:
- NUM_RULES, 4, number of guarded rules; width of the guard and enable buses.
- IDX_W, 2, width of a rule index; must equal ceil(log2(NUM_RULES)).
- STARVE_LIMIT, 15, consecutive eligible-but-not-granted evaluations that flag starvation.
- DEADLOCK_LIMIT, 8, consecutive evaluations with no true guard that flag deadlock.
- CNT_W, 16, width of the fire counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = continuous scheduling.
- step  in  1  one-cycle pulse; requests a single evaluate/fire while idle.
- guard_ok  in  NUM_RULES  bit i = guard of rule i is currently true.
- io_en_a  out  NUM_RULES  registered one-hot rule enable to `system`; all zeros when no rule fires.
- fired  out  1  high in the cycle io_en_a is non-zero.
- fired_idx  out  IDX_W  index of the rule being fired; valid when fired=1.
- fire_count  out  CNT_W  number of rules fired; saturates at all-ones.
- deadlock  out  1  sticky deadlock flag.
- starve  out  1  sticky starvation flag.
- starve_idx  out  IDX_W  index of the first rule that starved.
- busy  out  1  high whenever the state is not IDLE or HALT.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-FIRE):
  - io_en_a=0, fired=0, fired_idx=0, fire_count=0, deadlock=0, starve=0, starve_idx=0, busy=0.
  - Round-robin pointer ptr=0; state=IDLE; all starvation and deadlock counters cleared.
- States: IDLE, EVAL, FIRE, HALT.
- IDLE:
  - io_en_a=0.
  - run=1 -> EVAL with continuous mode.
  - run=0 and step=1 -> EVAL with single mode.
  - If run and step are both high, run wins.
- EVAL (io_en_a=0): guard_ok is sampled this cycle.
  - Grant: the first set bit of guard_ok searching ptr, ptr+1, ..., wrapping modulo NUM_RULES.
  - On a grant g: io_en_a is loaded with one-hot(g) for the next cycle; next state = FIRE; ptr <= (g+1) mod NUM_RULES; the deadlock counter clears.
  - If guard_ok=0: no grant; the deadlock counter increments.
    - Reaching DEADLOCK_LIMIT -> HALT with deadlock=1.
    - Otherwise, stay in EVAL in continuous mode, or return to IDLE in single mode.
- FIRE (exactly one cycle):
  - io_en_a=one-hot(g), fired=1, fired_idx=g; fire_count increments, saturating.
  - Next state: EVAL if continuous mode and run=1; otherwise IDLE.
  - run falling during FIRE still completes the fire; there is no truncation.
- Latency and throughput:
  - guard_ok sampled in EVAL at cycle t -> io_en_a asserted in cycle t+1 -> io_en_a=0 in cycle t+2 (next EVAL).
  - Maximum throughput is one rule every 2 cycles. The gap cycle lets `system` state and guards settle, so io_en_a is never asserted on stale guards.
- Starvation checker: per rule i, a saturating counter tracks ungranted eligible evaluations.
  - It increments in each EVAL where guard_ok[i]=1 and i was not granted.
  - It clears when i is granted or when guard_ok[i]=0 in EVAL.
  - When any counter reaches STARVE_LIMIT: starve=1 sticky, and starve_idx latches the lowest such index.
  - Later starvation events do not change starve_idx.
  - Starvation does not halt scheduling.
- HALT:
  - io_en_a=0; run and step are ignored.
  - Left only by reset.
- The step pulse is ignored outside IDLE.
- io_en_a is always zero or one-hot; two bits set at once is a design error.
- busy=1 in EVAL and FIRE.

Test Plan:
- Reset values: assert reset asynchronously mid-cycle during FIRE (io_en_a=4'b0001) -> io_en_a=0 immediately; every output returns to its reset value; ptr=0.
- Rotation: run=1, guard_ok=4'b1111 held -> io_en_a sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001; fire_count=5 after 5 fires.
- Pointer skip: run=1, ptr=0, guard_ok=4'b1010 -> grants 1, then 3, then 1; io_en_a=0010,0000,1000,0000,0010.
- Single-step: run=0, guard_ok=4'b0011, two step pulses 4 cycles apart -> exactly two fires (0001, then 0010), busy returns to 0 between them, and no further enables.
- Deadlock: run=1, guard_ok=0 held -> deadlock=1 after the 8th evaluation and the state is HALT. A later guard_ok=4'b1111 with run=1 produces no enables until reset.
- Starvation checker: force ptr behaviour via a bench override so rule 2 is never granted while guard_ok[2]=1 -> starve=1 and starve_idx=2 after 15 evaluations. Normal round-robin with guard_ok=4'b1111 for 200 cycles -> starve stays 0.
